// File: rtl/led_fade_pwm_if.sv
// Pattern-in / LED-drive-out bundle between a pattern generator and the PWM fade stage.
interface led_fade_pwm_if;
  logic        en;
  logic [15:0] led_in;
  logic [15:0] led_out;
  logic        busy;

  // Generator side drives enable and the raw pattern; the fade stage returns pin drive and activity.
  modport master (output en, led_in, input  led_out, busy);
  modport slave  (input  en, led_in, output led_out, busy);
endinterface

// File: rtl/led_fade_pwm.sv
// 16-channel LED output stage: lit bits show full brightness, dropped bits fade out
// linearly in DECAY_STEP decrements every DECAY_DIV cycles, rendered with a shared PWM counter.
module led_fade_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 1000000,
  parameter int DECAY_STEP = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  led_fade_pwm_if.slave  bus
);

  localparam int                  CH         = 16;
  localparam int                  DCW        = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX        = '1;
  localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);
  localparam logic [DCW-1:0]      DECAY_LAST = DCW'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
  logic [DCW-1:0]      decay_cnt_q, decay_cnt_d;
  logic [PWM_BITS-1:0] level_q [CH];
  logic [PWM_BITS-1:0] level_d [CH];
  logic [CH-1:0]       led_out_q,   led_out_d;
  logic                busy_q,      busy_d;
  logic                decay_tick;
  logic                any_level;

  always_comb begin
    decay_tick  = (decay_cnt_q == DECAY_LAST);
    pwm_cnt_d   = pwm_cnt_q;
    decay_cnt_d = decay_cnt_q;
    busy_d      = busy_q;
    led_out_d   = '0;
    any_level   = 1'b0;

    for (int i = 0; i < CH; i++) begin
      level_d[i] = level_q[i];
      any_level  = any_level | (level_q[i] != '0);
      // Full level forces 100% duty; otherwise level L is high for pwm_cnt 0..L-1.
      led_out_d[i] = bus.en & ((level_q[i] == MAX) | (level_q[i] > pwm_cnt_q));
      if (bus.en) begin
        if (bus.led_in[i]) begin
          level_d[i] = MAX;
        end else if (decay_tick) begin
          level_d[i] = (level_q[i] > STEP) ? (level_q[i] - STEP) : '0;
        end
      end
    end

    // Disabled: counters, levels and busy freeze while the pins are blanked.
    if (bus.en) begin
      pwm_cnt_d   = pwm_cnt_q + 1'b1;
      decay_cnt_d = decay_tick ? '0 : (decay_cnt_q + 1'b1);
      busy_d      = any_level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q   <= '0;
      decay_cnt_q <= '0;
      led_out_q   <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      led_out_q   <= led_out_d;
      busy_q      <= busy_d;
      for (int i = 0; i < CH; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign bus.led_out = led_out_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with PWM_BITS=4, DECAY_DIV=32, DECAY_STEP=4 (MAX=15).
module tb_led_fade_pwm;

  logic clk;
  logic rst_n;
  int   n;        // enabled edges since last reset release: pwm_cnt = n%16, decay_cnt = n%32
  int   n_checks;
  int   n_fail;

  led_fade_pwm_if bus_if ();

  led_fade_pwm #(
    .PWM_BITS   (4),
    .DECAY_DIV  (32),
    .DECAY_STEP (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; sampling happens on the following falling edge.
  task automatic edge_step();
    logic was_en;
    was_en = bus_if.en;
    @(negedge clk);
    if (was_en) n++;
  endtask

  task automatic adv_to(input int target);
    for (int k = 0; k < 1000 && n < target; k++) edge_step();
  endtask

  task automatic duty(input string tag, input int exp);
    int hi;
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      edge_step();
      hi += int'(bus_if.led_out[0]);
    end
    check(tag, hi, exp);
  endtask

  task automatic do_reset(input logic [15:0] pat);
    rst_n         = 1'b0;
    bus_if.en     = 1'b1;
    bus_if.led_in = pat;
    edge_step();
    rst_n = 1'b1;
    n     = 0;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    n             = 0;
    rst_n         = 1'b0;
    bus_if.en     = 1'b1;
    bus_if.led_in = 16'hFFFF;

    // Reset held with all inputs lit
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_led_out", bus_if.led_out, 16'h0000);
      check("rst_busy", bus_if.busy, 1'b0);
    end
    rst_n = 1'b1;
    n     = 0;
    edge_step();
    check("rel_e1_led_out", bus_if.led_out, 16'h0000);
    check("rel_e1_busy", bus_if.busy, 1'b0);
    edge_step();
    check("rel_e2_led_out", bus_if.led_out, 16'hFFFF);
    check("rel_e2_busy", bus_if.busy, 1'b1);

    // Steady on, through the decay tick at edge 32
    do_reset(16'h0001);
    edge_step();
    check("on_e1_led_out", bus_if.led_out, 16'h0000);
    check("on_e1_level0", dut.level_q[0], 4'd15);
    for (int k = 2; k <= 40; k++) begin
      edge_step();
      check("on_led_out", bus_if.led_out, 16'h0001);
      check("on_busy", bus_if.busy, 1'b1);
    end
    check("on_level0", dut.level_q[0], 4'd15);

    // Fade and saturation: ticks at edges 64, 96, 128, 160
    bus_if.led_in = 16'h0000;
    adv_to(63);
    check("fade_hold15", dut.level_q[0], 4'd15);
    check("fade_hold15_out", bus_if.led_out, 16'h0001);
    adv_to(64);
    check("fade_lvl11", dut.level_q[0], 4'd11);
    duty("duty11", 11);
    adv_to(95);
    check("fade_hold11", dut.level_q[0], 4'd11);
    adv_to(96);
    check("fade_lvl7", dut.level_q[0], 4'd7);
    duty("duty7", 7);
    adv_to(128);
    check("fade_lvl3", dut.level_q[0], 4'd3);
    duty("duty3", 3);
    adv_to(160);
    check("fade_lvl0", dut.level_q[0], 4'd0);
    check("fade_busy_lag", bus_if.busy, 1'b1);
    edge_step();
    check("fade_busy_drop", bus_if.busy, 1'b0);
    for (int k = 0; k < 20; k++) begin
      edge_step();
      check("fade_dark", bus_if.led_out, 16'h0000);
    end

    // Retrigger in the tick cycle while level0=7; channel 1 decays alongside
    do_reset(16'h0003);
    edge_step();
    bus_if.led_in = 16'h0000;
    adv_to(95);
    check("retrig_pre_lvl0", dut.level_q[0], 4'd7);
    check("retrig_pre_lvl1", dut.level_q[1], 4'd7);
    bus_if.led_in = 16'h0001;
    edge_step();
    check("retrig_lvl0", dut.level_q[0], 4'd15);
    check("retrig_lvl1", dut.level_q[1], 4'd3);

    // Enable gating at level0=7, n=70
    do_reset(16'h0001);
    edge_step();
    bus_if.led_in = 16'h0000;
    adv_to(70);
    check("gate_pre_lvl", dut.level_q[0], 4'd7);
    bus_if.en     = 1'b0;
    bus_if.led_in = 16'hFFFF;
    for (int k = 0; k < 40; k++) begin
      edge_step();
      check("gate_led_out", bus_if.led_out, 16'h0000);
      check("gate_busy", bus_if.busy, 1'b1);
    end
    check("gate_lvl", dut.level_q[0], 4'd7);
    check("gate_lvl1", dut.level_q[1], 4'd0);
    check("gate_pwm", dut.pwm_cnt_q, 4'd6);
    check("gate_decay", dut.decay_cnt_q, 5'd6);
    bus_if.led_in = 16'h0000;
    bus_if.en     = 1'b1;
    edge_step();
    check("gate_resume_out", bus_if.led_out, 16'h0001);
    adv_to(80);
    duty("gate_duty7", 7);
    check("gate_next_decay", dut.level_q[0], 4'd3);

    // Asynchronous reset mid-fade at level 11
    do_reset(16'hFFFF);
    edge_step();
    bus_if.led_in = 16'h0000;
    adv_to(40);
    check("arst_pre_lvl", dut.level_q[0], 4'd11);
    check("arst_pre_out", bus_if.led_out, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led_out", bus_if.led_out, 16'h0000);
    check("arst_busy", bus_if.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    for (int i = 0; i < 16; i++) begin
      check("arst_level", dut.level_q[i], 4'd0);
    end
    check("arst_pwm", dut.pwm_cnt_q, 4'd0);
    check("arst_decay", dut.decay_cnt_q, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
